mdc_share_sched: RTL and testbench



---
 rtl/mdc_sched_pkg.sv | 22 ++
 rtl/mdc_rr_arbiter.sv | 40 ++++
 rtl/mdc_share_sched.sv | 189 ++++++++++++++++++
 tb/tb_mdc_share_sched.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdc_sched_pkg.sv
// rtl/mdc_sched_pkg.sv - shared types and constants for the MDC share scheduler
package mdc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam int DEF_DATA_W = 15;
  localparam int DEF_MODE_W = 9;
  localparam int DEF_OUT_W  = 207;
  localparam int DEF_BEATS  = 16;

  // Index width that stays at least one bit wide for single-entry sets.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mdc_rr_arbiter.sv
// rtl/mdc_rr_arbiter.sv - round-robin picker scanning from ptr+1 modulo N_SRC
module mdc_rr_arbiter
  import mdc_sched_pkg::*;
#(
  parameter int  N_SRC = 2,
  localparam int IDW   = idx_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic [IDW-1:0]   gnt_o,
  output logic             any_o
);

  logic           hi_any;
  logic           lo_any;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;

  // Lowest requester above ptr wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        if (k > int'(ptr_i)) begin
          hi_any = 1'b1;
          hi_idx = IDW'(k);
        end else begin
          lo_any = 1'b1;
          lo_idx = IDW'(k);
        end
      end
    end
    any_o = hi_any | lo_any;
    gnt_o = hi_any ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/mdc_share_sched.sv
// rtl/mdc_share_sched.sv - time-shares one MDC core between N_SRC framed requesters
// Optional WAIT-state watchdog is built when MDC_SCHED_WATCHDOG_EN is defined.
module mdc_share_sched
  import mdc_sched_pkg::*;
#(
  parameter int  N_SRC       = 2,
  parameter int  BEATS       = DEF_BEATS,
  parameter int  DATA_W      = DEF_DATA_W,
  parameter int  MODE_W      = DEF_MODE_W,
  parameter int  OUT_W       = DEF_OUT_W,
  parameter int  TIMEOUT_CYC = 1024,
  localparam int IDW         = idx_w(N_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_SRC-1:0]          src_valid,
  input  logic [N_SRC*DATA_W-1:0]   src_data,
  input  logic [N_SRC*MODE_W-1:0]   src_mode,
  output logic [N_SRC-1:0]          src_ready,
  output logic                      mdc_in_valid,
  output logic [DATA_W-1:0]         mdc_in_data,
  output logic [MODE_W-1:0]         mdc_in_mode,
  input  logic                      mdc_out_valid,
  input  logic [OUT_W-1:0]          mdc_out_data,
  output logic                      resp_valid,
  output logic [OUT_W-1:0]          resp_data,
  output logic [IDW-1:0]            resp_id,
  output logic                      resp_err,
  input  logic                      resp_ready,
  output logic                      busy
);

  localparam int               CNT_W = idx_w(BEATS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BEATS - 1);

  if (N_SRC < 1 || N_SRC > 8 || BEATS < 1 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("mdc_share_sched: unsupported parameter set");
  end

  state_e             state_q;
  logic [IDW-1:0]     gnt_q;
  logic [IDW-1:0]     ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [MODE_W-1:0]  mode_q;
  logic [DATA_W-1:0]  beat_buf_q [BEATS];
  logic               in_valid_q;
  logic [DATA_W-1:0]  in_data_q;
  logic [MODE_W-1:0]  in_mode_q;
  logic               resp_valid_q;
  logic [OUT_W-1:0]   resp_data_q;
  logic [IDW-1:0]     resp_id_q;
  logic [IDW-1:0]     arb_gnt;
  logic               arb_any;
  logic               beat_take;
  logic [DATA_W-1:0]  cur_data;
  logic [MODE_W-1:0]  cur_mode;

`ifdef MDC_SCHED_WATCHDOG_EN
  localparam int               WD_W    = idx_w(TIMEOUT_CYC);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0]  wd_q;
  logic             resp_err_q;
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  mdc_rr_arbiter #(
    .N_SRC (N_SRC)
  ) u_arb (
    .req_i (src_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .any_o (arb_any)
  );

  assign cur_data  = src_data[int'(gnt_q) * DATA_W +: DATA_W];
  assign cur_mode  = src_mode[int'(gnt_q) * MODE_W +: MODE_W];
  assign beat_take = (state_q == COLLECT) && src_valid[gnt_q];
  assign cnt_d     = cnt_q + CNT_W'(1);

  always_comb begin
    src_ready = '0;
    if (state_q == COLLECT) src_ready[gnt_q] = 1'b1;
  end

  assign mdc_in_valid = in_valid_q;
  assign mdc_in_data  = in_data_q;
  assign mdc_in_mode  = in_mode_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_id      = resp_id_q;
  assign busy         = (state_q != IDLE);

  // Frame storage needs no reset: a partial frame is never replayed.
  always_ff @(posedge clk) begin
    if (beat_take) beat_buf_q[cnt_q] <= cur_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      ptr_q        <= IDW'(N_SRC - 1);
      cnt_q        <= '0;
      mode_q       <= '0;
      in_valid_q   <= 1'b0;
      in_data_q    <= '0;
      in_mode_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
`ifdef MDC_SCHED_WATCHDOG_EN
      wd_q         <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            gnt_q   <= arb_gnt;
            ptr_q   <= arb_gnt;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (beat_take) begin
            if (cnt_q == '0) mode_q <= cur_mode;
            if (cnt_q == LAST) begin
              // Preload the first replay beat so the burst starts next cycle.
              cnt_q      <= '0;
              state_q    <= ISSUE;
              in_valid_q <= 1'b1;
              in_data_q  <= (cnt_q == '0) ? cur_data : beat_buf_q[0];
              in_mode_q  <= (cnt_q == '0) ? cur_mode : mode_q;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        ISSUE: begin
          if (cnt_q == LAST) begin
            cnt_q      <= '0;
            in_valid_q <= 1'b0;
            in_data_q  <= '0;
            in_mode_q  <= '0;
            state_q    <= WAIT;
`ifdef MDC_SCHED_WATCHDOG_EN
            wd_q       <= '0;
`endif
          end else begin
            cnt_q     <= cnt_d;
            in_data_q <= beat_buf_q[cnt_d];
            in_mode_q <= '0;
          end
        end
        WAIT: begin
          if (mdc_out_valid) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= mdc_out_data;
            resp_id_q    <= gnt_q;
            state_q      <= RESP;
`ifdef MDC_SCHED_WATCHDOG_EN
            resp_err_q   <= 1'b0;
          end else if (wd_q == WD_LAST) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= '0;
            resp_id_q    <= gnt_q;
            resp_err_q   <= 1'b1;
            state_q      <= RESP;
          end else begin
            wd_q <= wd_q + WD_W'(1);
`endif
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdc_share_sched.sv
// tb/tb_mdc_share_sched.sv - scoreboard bench for mdc_share_sched (watchdog case under MDC_SCHED_WATCHDOG_EN)
module tb_mdc_share_sched;

  localparam int N_SRC       = 2;
  localparam int BEATS       = 16;
  localparam int DATA_W      = 15;
  localparam int MODE_W      = 9;
  localparam int OUT_W       = 207;
  localparam int TIMEOUT_CYC = 32;
  localparam int IDW         = 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [MODE_W-1:0] mode;
  } beat_t;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [IDW-1:0]   id;
    logic             err;
  } resp_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N_SRC-1:0]        src_valid = '0;
  logic [N_SRC*DATA_W-1:0] src_data = '0;
  logic [N_SRC*MODE_W-1:0] src_mode = '0;
  logic [N_SRC-1:0]        src_ready;
  logic                    mdc_in_valid;
  logic [DATA_W-1:0]       mdc_in_data;
  logic [MODE_W-1:0]       mdc_in_mode;
  logic                    mdc_out_valid;
  logic [OUT_W-1:0]        mdc_out_data;
  logic                    resp_valid;
  logic [OUT_W-1:0]        resp_data;
  logic [IDW-1:0]          resp_id;
  logic                    resp_err;
  logic                    resp_ready = 1'b0;
  logic                    busy;

  logic                    model_valid = 1'b0;
  logic [OUT_W-1:0]        model_data = '0;
  logic                    spur_valid = 1'b0;
  int                      model_cnt = 0;
  int                      run = 0;
  beat_t                   mon_b;

  beat_t                   beat_q[$];
  resp_t                   resp_q[$];
  logic [OUT_W-1:0]        res_q[$];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  assign mdc_out_valid = model_valid | spur_valid;
  assign mdc_out_data  = spur_valid ? {OUT_W{1'b1}} : model_data;

  always #5 clk = ~clk;

  mdc_share_sched #(
    .N_SRC       (N_SRC),
    .BEATS       (BEATS),
    .DATA_W      (DATA_W),
    .MODE_W      (MODE_W),
    .OUT_W       (OUT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .src_valid     (src_valid),
    .src_data      (src_data),
    .src_mode      (src_mode),
    .src_ready     (src_ready),
    .mdc_in_valid  (mdc_in_valid),
    .mdc_in_data   (mdc_in_data),
    .mdc_in_mode   (mdc_in_mode),
    .mdc_out_valid (mdc_out_valid),
    .mdc_out_data  (mdc_out_data),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_id       (resp_id),
    .resp_err      (resp_err),
    .resp_ready    (resp_ready),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] mk_res(input logic [31:0] a);
    logic [OUT_W-1:0] r;
    r = '0;
    r[31:0]            = a;
    r[100 +: 32]       = a ^ 32'h5A5A_5A5A;
    r[OUT_W-1 -: 32]   = ~a;
    return r;
  endfunction

  task automatic push_frame(input int s, input logic [DATA_W-1:0] base, input logic [MODE_W-1:0] mode,
                            input logic [OUT_W-1:0] res, input bit with_res);
    for (int b = 0; b < BEATS; b++)
      beat_q.push_back('{data: base + DATA_W'(b), mode: (b == 0) ? mode : MODE_W'(0)});
    if (with_res) begin
      res_q.push_back(res);
      resp_q.push_back('{data: res, id: IDW'(s), err: 1'b0});
    end
  endtask

  task automatic drive_frame(input int s, input int gap, input logic [MODE_W-1:0] mode,
                             input logic [DATA_W-1:0] base);
    for (int b = 0; b < BEATS; b++) begin
      int waited;
      waited = 0;
      src_valid[s] = 1'b1;
      src_data[s*DATA_W +: DATA_W] = base + DATA_W'(b);
      src_mode[s*MODE_W +: MODE_W] = (b == 0) ? mode : MODE_W'($urandom);
      while (!src_ready[s] && waited < 2000) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 2000) begin
        chk("src_ready_timeout", OUT_W'(src_ready[s]), OUT_W'(1));
        src_valid[s] = 1'b0;
        return;
      end
      @(negedge clk);
      if (gap > 0) begin
        src_valid[s] = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    src_valid[s] = 1'b0;
  endtask

  task automatic take_resp(input int hold);
    int    w;
    resp_t e;
    w = 0;
    while (!resp_valid && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("resp_arrived", OUT_W'(resp_valid), OUT_W'(1));
    chk("resp_expected", OUT_W'(resp_q.size() != 0), OUT_W'(1));
    if (!resp_valid || resp_q.size() == 0) return;
    e = resp_q.pop_front();
    chk("resp_data", resp_data, e.data);
    chk("resp_id", OUT_W'(resp_id), OUT_W'(e.id));
    chk("resp_err", OUT_W'(resp_err), OUT_W'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", OUT_W'(resp_valid), OUT_W'(1));
      chk("hold_data", resp_data, e.data);
      chk("hold_id", OUT_W'(resp_id), OUT_W'(e.id));
      chk("hold_no_grant", OUT_W'(src_ready), OUT_W'(0));
      chk("hold_no_issue", OUT_W'(mdc_in_valid), OUT_W'(0));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_clear_valid", OUT_W'(resp_valid), OUT_W'(0));
    chk("resp_clear_data", resp_data, OUT_W'(0));
    chk("idle_after_resp", OUT_W'(busy), OUT_W'(0));
    chk("idle_no_ready", OUT_W'(src_ready), OUT_W'(0));
  endtask

  // Beat scoreboard plus a small MDC model that answers each complete burst.
  always @(negedge clk) begin
    model_valid = 1'b0;
    if (rst) begin
      run       = 0;
      model_cnt = 0;
    end else begin
      if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0 && res_q.size() != 0) begin
          model_valid = 1'b1;
          model_data  = res_q.pop_front();
        end
      end
      if (mdc_in_valid) begin
        chk("beat_expected", OUT_W'(beat_q.size() != 0), OUT_W'(1));
        if (beat_q.size() != 0) begin
          mon_b = beat_q.pop_front();
          chk("issue_data", OUT_W'(mdc_in_data), OUT_W'(mon_b.data));
          chk("issue_mode", OUT_W'(mdc_in_mode), OUT_W'(mon_b.mode));
        end
        run++;
      end else if (run != 0) begin
        chk("burst_len", OUT_W'(run), OUT_W'(BEATS));
        if (run == BEATS && res_q.size() != 0) model_cnt = 3;
        run = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    @(negedge clk);
    chk("rst_src_ready", OUT_W'(src_ready), OUT_W'(0));
    chk("rst_in_valid", OUT_W'(mdc_in_valid), OUT_W'(0));
    chk("rst_in_data", OUT_W'(mdc_in_data), OUT_W'(0));
    chk("rst_in_mode", OUT_W'(mdc_in_mode), OUT_W'(0));
    chk("rst_resp_valid", OUT_W'(resp_valid), OUT_W'(0));
    chk("rst_resp_data", resp_data, OUT_W'(0));
    chk("rst_resp_id", OUT_W'(resp_id), OUT_W'(0));
    chk("rst_resp_err", OUT_W'(resp_err), OUT_W'(0));
    chk("rst_busy", OUT_W'(busy), OUT_W'(0));
    @(negedge clk);
    rst = 1'b0;

    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    @(negedge clk);
    chk("idle_spurious_ignored", OUT_W'(resp_valid), OUT_W'(0));
    chk("idle_spurious_busy", OUT_W'(busy), OUT_W'(0));

    // Both sources request together after reset: 0, 1, then 0, 1 again.
    for (int rep = 0; rep < 2; rep++) begin
      push_frame(0, DATA_W'('h200 + rep * 'h40), 9'h0C3, mk_res(32'hA000_0000 + rep), 1'b1);
      push_frame(1, DATA_W'('h300 + rep * 'h40), 9'h1C3, mk_res(32'hB000_0000 + rep), 1'b1);
      fork
        drive_frame(0, 0, 9'h0C3, DATA_W'('h200 + rep * 'h40));
        drive_frame(1, 0, 9'h1C3, DATA_W'('h300 + rep * 'h40));
        begin
          take_resp(0);
          take_resp(0);
        end
      join
    end

    // Single source 0 with grant and issue latency, plus a stray MDC pulse during ISSUE.
    push_frame(0, 15'h100, 9'h0A5, 207'h1234, 1'b1);
    src_valid[0] = 1'b1;
    src_data[0 +: DATA_W] = 15'h100;
    src_mode[0 +: MODE_W] = 9'h0A5;
    chk("idle_no_accept", OUT_W'(src_ready), OUT_W'(0));
    @(negedge clk);
    chk("grant_latency", OUT_W'(src_ready), OUT_W'(2'b01));
    chk("busy_collect", OUT_W'(busy), OUT_W'(1));
    drive_frame(0, 0, 9'h0A5, 15'h100);
    chk("issue_latency", OUT_W'(mdc_in_valid), OUT_W'(1));
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    take_resp(0);

    // Source 1 with gapped beats; source 0 waits pending while the response is held.
    push_frame(1, 15'h0, 9'h111, mk_res(32'hC0DE_0001), 1'b1);
    push_frame(0, 15'h40, 9'h022, mk_res(32'hC0DE_0002), 1'b1);
    fork
      drive_frame(1, 3, 9'h111, 15'h0);
      begin
        repeat (5) @(negedge clk);
        drive_frame(0, 0, 9'h022, 15'h40);
      end
      begin
        take_resp(10);
        take_resp(0);
      end
    join

    // Reset during ISSUE cycle 7 of a source-0 frame.
    push_frame(0, 15'h600, 9'h1FF, '0, 1'b0);
    drive_frame(0, 0, 9'h1FF, 15'h600);
    repeat (7) @(negedge clk);
    chk("issue_c7_valid", OUT_W'(mdc_in_valid), OUT_W'(1));
    chk("issue_c7_data", OUT_W'(mdc_in_data), OUT_W'(15'h607));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_in_valid", OUT_W'(mdc_in_valid), OUT_W'(0));
    chk("async_rst_in_data", OUT_W'(mdc_in_data), OUT_W'(0));
    chk("async_rst_in_mode", OUT_W'(mdc_in_mode), OUT_W'(0));
    chk("async_rst_busy", OUT_W'(busy), OUT_W'(0));
    chk("async_rst_resp_valid", OUT_W'(resp_valid), OUT_W'(0));
    beat_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_frame(0, 15'h700, 9'h033, mk_res(32'hD000_0000), 1'b1);
    push_frame(1, 15'h780, 9'h044, mk_res(32'hD000_0001), 1'b1);
    fork
      drive_frame(0, 0, 9'h033, 15'h700);
      drive_frame(1, 0, 9'h044, 15'h780);
      begin
        take_resp(0);
        take_resp(0);
      end
    join

`ifdef MDC_SCHED_WATCHDOG_EN
    begin
      int w;
      push_frame(0, 15'h50, 9'h003, '0, 1'b0);
      resp_q.push_back('{data: '0, id: '0, err: 1'b1});
      drive_frame(0, 0, 9'h003, 15'h50);
      w = 0;
      while (mdc_in_valid && w < 100) begin
        @(negedge clk);
        w++;
      end
      repeat (TIMEOUT_CYC - 1) @(negedge clk);
      chk("wd_not_yet", OUT_W'(resp_valid), OUT_W'(0));
      @(negedge clk);
      chk("wd_fire", OUT_W'(resp_valid), OUT_W'(1));
      take_resp(0);
    end
`endif

    chk("beat_queue_drained", OUT_W'(beat_q.size()), OUT_W'(0));
    chk("resp_queue_drained", OUT_W'(resp_q.size()), OUT_W'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
